// File: rtl/cdf_pkg.sv
// Shared types and constants for the CDF sequencing logic.
// The controller and interface import this package.
package cdf_pkg;

    localparam int CDF_NUM_BINS      = 256;
    localparam int CDF_BINS_PER_READ = 8;
    localparam int CDF_WR_BASE       = 64;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLEAR  = 4'd1,
        READ   = 4'd2,
        WAIT   = 4'd3,
        READY  = 4'd4,
        SETTLE = 4'd5,
        DONE0  = 4'd6,
        DONE1  = 4'd7,
        GAP    = 4'd8,
        FINISH = 4'd9
    } cdf_state_e;

endpackage

// File: rtl/cdf_controller_if.sv
// Control bundle between the equalization sequencer, the CDF controller and the CDF datapath.
// The controller takes the master modport; the sequencer/datapath side takes the slave modport.
interface cdf_controller_if import cdf_pkg::*; #(
    parameter int ITER_W = $clog2(CDF_NUM_BINS / CDF_BINS_PER_READ)
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              dp_clear;
    logic              read_first_value;
    logic              read_next_value;
    logic              scratch_mem_read_ready;
    logic              cdf_computation_done;
    logic              cdf_done;
    logic [ITER_W-1:0] iter;

    modport master (
        input  start, abort,
        output busy, dp_clear, read_first_value, read_next_value,
               scratch_mem_read_ready, cdf_computation_done, cdf_done, iter
    );

    modport slave (
        output start, abort,
        input  busy, dp_clear, read_first_value, read_next_value,
               scratch_mem_read_ready, cdf_computation_done, cdf_done, iter
    );

endinterface

// File: rtl/cdf_controller.sv
// Sequencing FSM for the CDF datapath: one frame runs ITERS read/compute/write iterations.
// Outputs are registered copies decoded from the next state, so they line up with the state.
module cdf_controller import cdf_pkg::*; #(
    parameter int NUM_BINS      = CDF_NUM_BINS,
    parameter int BINS_PER_READ = CDF_BINS_PER_READ,
    parameter int READ_WAIT     = 3,
    parameter int SETTLE_CYC    = 2
) (
    input logic              clk,
    input logic              reset,
    cdf_controller_if.master bus
);

    localparam int ITERS   = NUM_BINS / BINS_PER_READ;
    localparam int ITER_W  = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int CNT_MAX = (READ_WAIT > SETTLE_CYC) ? READ_WAIT : SETTLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]  RW_LOAD   = CNT_W'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0]  SC_LOAD   = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERS - 1);

    cdf_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic busy_q, busy_d, clr_q, clr_d, rfv_q, rfv_d, rnv_q, rnv_d;
    logic rdy_q, rdy_d, cdone_q, cdone_d, fin_q, fin_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            iter_d  = '0;
        end else begin
            case (state_q)
                IDLE:   if (bus.start) state_d = CLEAR;
                CLEAR:  state_d = READ;
                // A zero-length wait skips the state instead of spending a cycle in it
                READ: begin
                    if (READ_WAIT > 0) begin
                        state_d = WAIT;
                        cnt_d   = RW_LOAD;
                    end else begin
                        state_d = READY;
                    end
                end
                WAIT:   if (cnt_q == '0) state_d = READY; else cnt_d = cnt_q - 1'b1;
                READY: begin
                    if (SETTLE_CYC > 0) begin
                        state_d = SETTLE;
                        cnt_d   = SC_LOAD;
                    end else begin
                        state_d = DONE0;
                    end
                end
                SETTLE: if (cnt_q == '0) state_d = DONE0; else cnt_d = cnt_q - 1'b1;
                DONE0:  state_d = DONE1;
                DONE1:  state_d = GAP;
                GAP: begin
                    if (iter_q == ITER_LAST) begin
                        state_d = FINISH;
                    end else begin
                        iter_d  = iter_q + 1'b1;
                        state_d = READ;
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    iter_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode looks at the next state and next iteration so the registers align with the state
    always_comb begin
        busy_d  = (state_d != IDLE);
        clr_d   = (state_d == CLEAR);
        rfv_d   = (state_d == READ) && (iter_d == '0);
        rnv_d   = (state_d == READ) && (iter_d != '0);
        rdy_d   = (state_d == READY);
        cdone_d = (state_d == DONE0) || (state_d == DONE1);
        fin_d   = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            rfv_q   <= 1'b0;
            rnv_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cdone_q <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            rfv_q   <= rfv_d;
            rnv_q   <= rnv_d;
            rdy_q   <= rdy_d;
            cdone_q <= cdone_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.busy                   = busy_q;
    assign bus.dp_clear               = clr_q;
    assign bus.read_first_value       = rfv_q;
    assign bus.read_next_value        = rnv_q;
    assign bus.scratch_mem_read_ready = rdy_q;
    assign bus.cdf_computation_done   = cdone_q;
    assign bus.cdf_done               = fin_q;
    assign bus.iter                   = iter_q;

endmodule
